// File: rtl/data_mem_unit_pkg.sv
// Shared definitions for the MEM-stage data memory: access-type and FSM state encodings
// plus small access-type helpers used by the top and the lane extractor.
package mem_pkg;

    typedef enum logic [2:0] {
        MT_W  = 3'd0,
        MT_H  = 3'd1,
        MT_HU = 3'd2,
        MT_B  = 3'd3,
        MT_BU = 3'd4
    } mem_type_e;

    typedef enum logic [2:0] {
        ST_CLR  = 3'd0,
        ST_IDLE = 3'd1,
        ST_BUSY = 3'd2
    } dm_state_e;

    function automatic logic is_half(input logic [2:0] t);
        return (t == MT_H) || (t == MT_HU);
    endfunction

    function automatic logic is_byte(input logic [2:0] t);
        return (t == MT_B) || (t == MT_BU);
    endfunction

    // Unknown encodings are handled as full-word accesses everywhere.
    function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] lo);
        if (is_byte(t))
            return 1'b0;
        else if (is_half(t))
            return lo[0];
        else
            return |lo;
    endfunction

endpackage

// File: rtl/data_mem_unit_lane_ext.sv
// dm_lane_ext: combinational store lane merge and load lane extract/extend,
// selected by access type and byte offset.
module dm_lane_ext
    import mem_pkg::*;
(
    input  logic [2:0]  i_type,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_merged,
    output logic [31:0] o_ldata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        unique case (i_lane)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    end

    // Store merge: HU/BU stores behave as H/B.
    always_comb begin
        o_merged = i_word;
        if (is_byte(i_type)) begin
            unique case (i_lane)
                2'd0: o_merged[7:0]   = i_wdata[7:0];
                2'd1: o_merged[15:8]  = i_wdata[7:0];
                2'd2: o_merged[23:16] = i_wdata[7:0];
                2'd3: o_merged[31:24] = i_wdata[7:0];
            endcase
        end else if (is_half(i_type)) begin
            if (i_lane[1])
                o_merged[31:16] = i_wdata[15:0];
            else
                o_merged[15:0] = i_wdata[15:0];
        end else begin
            o_merged = i_wdata;
        end
    end

    always_comb begin
        o_ldata = i_word;
        case (i_type)
            MT_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
            MT_BU:   o_ldata = {24'd0, w_byte};
            MT_H:    o_ldata = {{16{w_half[15]}}, w_half};
            MT_HU:   o_ldata = {16'd0, w_half};
            default: o_ldata = i_word;
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: MEM-stage data memory with sub-word access, address exceptions,
// configurable wait states and a post-reset clear sweep. Define DM_TRACE_EN to print committed stores.
module data_mem_unit
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 3072,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned WAIT_CYC  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        exc_adel,
    output logic        exc_ades
);

    localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    dm_state_e        r_state, w_next;
    logic [3:0]       r_cnt, w_cnt_next;
    logic [IDXW-1:0]  r_clr_idx;
    logic [31:0]      r_mem [DEPTH];

    logic [32:0]      w_off;
    logic             w_in_range, w_misal, w_legal;
    logic [IDXW-1:0]  w_idx;
    logic [31:0]      w_rword, w_merged, w_ldata;
    logic             w_commit, w_rvalid;
    logic             w_unused_off;

    // Borrow out of the 33-bit subtract flags addresses below BASE_ADDR.
    assign w_off        = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign w_in_range   = !w_off[32] && (w_off[31:0] < SPAN);
    assign w_misal      = is_misaligned(req_type, req_addr[1:0]);
    assign w_legal      = w_in_range && !w_misal;
    assign w_idx        = w_off[IDXW+1:2];
    assign w_rword      = w_in_range ? r_mem[w_idx] : '0;
    assign w_unused_off = ^w_off;

    dm_lane_ext u_lane (
        .i_type   (req_type),
        .i_lane   (req_addr[1:0]),
        .i_word   (w_rword),
        .i_wdata  (req_wdata),
        .o_merged (w_merged),
        .o_ldata  (w_ldata)
    );

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        stall_o    = 1'b0;
        w_rvalid   = 1'b0;
        w_commit   = 1'b0;
        exc_adel   = 1'b0;
        exc_ades   = 1'b0;
        unique case (r_state)
            ST_CLR: begin
                stall_o = 1'b1;
                if (r_clr_idx == IDXW'(DEPTH - 1))
                    w_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_valid) begin
                    if (!w_legal) begin
                        exc_adel = !req_we;
                        exc_ades = req_we;
                    end else if (WAIT_CYC == 0) begin
                        w_commit = req_we;
                        w_rvalid = !req_we;
                    end else begin
                        stall_o    = 1'b1;
                        w_cnt_next = 4'(WAIT_CYC - 1);
                        w_next     = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt != 4'd0) begin
                    stall_o    = 1'b1;
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_commit = req_we;
                    w_rvalid = !req_we;
                    w_next   = ST_IDLE;
                end
            end
            default: w_next = ST_CLR;
        endcase
    end

    assign rvalid_o = w_rvalid;
    assign rdata_o  = w_rvalid ? w_ldata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_CLR;
            r_cnt     <= '0;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == ST_CLR)
                r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    // Storage has no reset; the CLR sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLR)
            r_mem[r_clr_idx] <= '0;
        else if (w_commit)
            r_mem[w_idx] <= w_merged;
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && w_commit)
            $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, w_merged);
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^req_pc;
`endif

endmodule
